// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
// The request side follows a req/gnt handshake, and the read side returns data with rvalid.
interface mem_stage_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                      dmem_req;
   logic                      dmem_we;
   logic [ADDR_WIDTH-1:0]     dmem_addr;
   logic [DATA_WIDTH/8-1:0]   dmem_be;
   logic [DATA_WIDTH-1:0]     dmem_wdata;
   logic                      dmem_gnt;
   logic                      dmem_rvalid;
   logic [DATA_WIDTH-1:0]     dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_gnt, dmem_rvalid, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_gnt, dmem_rvalid, dmem_rdata
   );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: drives loads and stores onto the data-memory bus and holds the MEM/WB register.
// While an access is outstanding, stall freezes the upstream stages.
module mem_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] opr_res,
   input  logic [DATA_WIDTH-1:0] opr_b,
   input  logic [4:0]            rd,
   input  logic [DATA_WIDTH-1:0] pc4,
   input  logic                  rf_en,
   input  logic                  dm_en,
   input  logic [1:0]            wb_sel,
   input  logic [2:0]            lsuop,
   mem_stage_if.master           dmem,
   output logic                  stall,
   output logic                  misalign,
   output logic                  wb_valid,
   output logic [4:0]            wb_rd,
   output logic                  wb_rf_en,
   output logic [DATA_WIDTH-1:0] wb_data
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t                  state_reg, state_next;
   logic                    wb_valid_reg, wb_rf_en_reg, misalign_reg;
   logic [4:0]              wb_rd_reg;
   logic [DATA_WIDTH-1:0]   wb_data_reg, wb_data_next, load_data;
   logic [1:0]              a;
   logic                    is_store, is_load, is_mem, misaligned, mem_go;
   logic                    req, complete;
   logic [7:0]              rbyte [4];
   logic [15:0]             rhalf [2];

   assign a        = opr_res[1:0];
   assign is_store = dm_en;
   assign is_load  = ~dm_en & (wb_sel == 2'd2);
   assign is_mem   = in_valid & (is_store | is_load);
   assign mem_go   = is_mem & ~misaligned;

   always_comb begin
      case (lsuop[1:0])
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = a[0];
         default: misaligned = (a != 2'b00);
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (mem_go) begin
               if (!dmem.dmem_gnt) state_next = REQ;
               else if (is_load)   state_next = WAIT;
            end
         end
         REQ:     if (dmem.dmem_gnt)    state_next = is_load ? WAIT : IDLE;
         WAIT:    if (dmem.dmem_rvalid) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic; misaligned and non-memory ops complete straight from IDLE
   always_comb begin
      req      = 1'b0;
      complete = 1'b0;
      case (state_reg)
         IDLE: begin
            req      = mem_go;
            complete = in_valid & (~mem_go | (is_store & dmem.dmem_gnt));
         end
         REQ: begin
            req      = 1'b1;
            complete = is_store & dmem.dmem_gnt;
         end
         WAIT:    complete = dmem.dmem_rvalid;
         default: ;
      endcase
   end

   // The completing cycle releases the pipeline, so it never stalls
   assign stall         = ~rst & ~complete & ((state_reg != IDLE) | mem_go);
   assign dmem.dmem_req  = req & ~rst;
   assign dmem.dmem_we   = is_store;
   assign dmem.dmem_addr = {opr_res[ADDR_WIDTH-1:2], 2'b00};

   always_comb begin
      case (lsuop[1:0])
         2'b00: begin
            dmem.dmem_be    = 4'b0001 << a;
            dmem.dmem_wdata = {4{opr_b[7:0]}};
         end
         2'b01: begin
            dmem.dmem_be    = 4'b0011 << a;
            dmem.dmem_wdata = {2{opr_b[15:0]}};
         end
         default: begin
            dmem.dmem_be    = 4'hF;
            dmem.dmem_wdata = opr_b;
         end
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_byte
         assign rbyte[gi] = dmem.dmem_rdata[8*gi +: 8];
      end
      for (gi = 0; gi < 2; gi++) begin : g_half
         assign rhalf[gi] = dmem.dmem_rdata[16*gi +: 16];
      end
   endgenerate

   always_comb begin
      case (lsuop)
         3'b000:  load_data = {{24{rbyte[a][7]}}, rbyte[a]};
         3'b100:  load_data = {24'd0, rbyte[a]};
         3'b001:  load_data = {{16{rhalf[a[1]][15]}}, rhalf[a[1]]};
         3'b101:  load_data = {16'd0, rhalf[a[1]]};
         default: load_data = dmem.dmem_rdata;
      endcase
   end

   always_comb begin
      case (wb_sel)
         2'd1:    wb_data_next = pc4;
         2'd2:    wb_data_next = load_data;
         default: wb_data_next = opr_res;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid_reg <= 1'b0;
         wb_rd_reg    <= '0;
         wb_rf_en_reg <= 1'b0;
         wb_data_reg  <= '0;
         misalign_reg <= 1'b0;
      end else begin
         wb_valid_reg <= complete;
         misalign_reg <= complete & is_mem & misaligned;
         if (complete) begin
            wb_rd_reg    <= rd;
            wb_rf_en_reg <= rf_en & ~(is_mem & misaligned);
            wb_data_reg  <= wb_data_next;
         end
      end
   end

   assign wb_valid = wb_valid_reg;
   assign wb_rd    = wb_rd_reg;
   assign wb_rf_en = wb_rf_en_reg;
   assign wb_data  = wb_data_reg;
   assign misalign = misalign_reg;
endmodule
